// File: rtl/micro_seq.sv
// ---------------------------------------------------------------------------
// micro_seq - micro-program sequencer
//
// Owns the micro-program counter (uPC) and selects the next control-store
// address every cycle. The sources are increment, jump, flag-conditional
// branch, opcode dispatch, call/return through a small LIFO, wait-for-ready
// and return to fetch.
//
// Parameters
//   UADDR_W      control-store address width (>= 8)
//   STACK_DEPTH  return-address stack entries (power of two, >= 2)
//   FETCH_ADDR   fetch-routine entry and uPC reset value
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   stall      global hold: uPC, stack and error flags frozen
//   seq_op     next-address op from the current microinstruction
//   cond_sel   branch condition for CJMP
//   uaddr_in   jump/call target field
//   Opcode     instruction opcode for DISPATCH
//   ZF, CF     zero and carry flags
//   ready      external completion for WAIT
//   uaddr      current uPC (registered), drives the control store
//   waiting    combinational: WAIT op while ready is low
//   stack_ovf  sticky: CALL issued with the stack full
//   stack_unf  sticky: RET issued with the stack empty
// ---------------------------------------------------------------------------
module micro_seq #(
    parameter int unsigned UADDR_W     = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned FETCH_ADDR  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic [2:0]         seq_op,
    input  logic [2:0]         cond_sel,
    input  logic [UADDR_W-1:0] uaddr_in,
    input  logic [4:0]         Opcode,
    input  logic               ZF,
    input  logic               CF,
    input  logic               ready,
    output logic [UADDR_W-1:0] uaddr,
    output logic               waiting,
    output logic               stack_ovf,
    output logic               stack_unf
);

    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    // seq_op encodings
    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_CJMP     = 3'd2;
    localparam logic [2:0] OP_DISPATCH = 3'd3;
    localparam logic [2:0] OP_CALL     = 3'd4;
    localparam logic [2:0] OP_RET      = 3'd5;
    localparam logic [2:0] OP_WAIT     = 3'd6;
    localparam logic [2:0] OP_FETCH    = 3'd7;

    // cond_sel encodings
    localparam logic [2:0] CC_EQ     = 3'd0;
    localparam logic [2:0] CC_NE     = 3'd1;
    localparam logic [2:0] CC_HI     = 3'd2;
    localparam logic [2:0] CC_HS     = 3'd3;
    localparam logic [2:0] CC_LO     = 3'd4;
    localparam logic [2:0] CC_LS     = 3'd5;
    localparam logic [2:0] CC_ALWAYS = 3'd6;
    localparam logic [2:0] CC_NEVER  = 3'd7;

    localparam logic [UADDR_W-1:0] FETCH_UADDR = UADDR_W'(FETCH_ADDR);
    localparam logic [PTR_W-1:0]   SP_FULL     = PTR_W'(STACK_DEPTH);

    logic [UADDR_W-1:0] upc_q;
    logic [UADDR_W-1:0] upc_d;
    logic [PTR_W-1:0]   sp_q;
    logic [PTR_W-1:0]   sp_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               unf_q;
    logic               unf_d;
    logic               push_en;

    logic [UADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic [UADDR_W-1:0] upc_inc;
    logic [UADDR_W-1:0] dispatch_addr;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;
    logic               stack_full;
    logic               stack_empty;
    logic               cond_true;

    // Address helpers; the increment wraps naturally at 2^UADDR_W
    assign upc_inc       = upc_q + UADDR_W'(1);
    assign dispatch_addr = UADDR_W'({Opcode, 3'b000});
    assign push_idx      = IDX_W'(sp_q);
    assign pop_idx       = IDX_W'(sp_q - PTR_W'(1));
    assign stack_full    = (sp_q == SP_FULL);
    assign stack_empty   = (sp_q == PTR_W'(0));

    // Branch condition decode, flags taken from the current cycle
    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            CC_EQ:     cond_true = ZF;
            CC_NE:     cond_true = ~ZF;
            CC_HI:     cond_true = ~CF & ~ZF;
            CC_HS:     cond_true = ~CF;
            CC_LO:     cond_true = CF;
            CC_LS:     cond_true = CF | ZF;
            CC_ALWAYS: cond_true = 1'b1;
            CC_NEVER:  cond_true = 1'b0;
            default:   cond_true = 1'b0;
        endcase
    end

    // Next-state logic; stall leaves every piece of state untouched
    always_comb begin
        upc_d   = upc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (!stall) begin
            case (seq_op)
                OP_NEXT:     upc_d = upc_inc;
                OP_JUMP:     upc_d = uaddr_in;
                OP_CJMP:     upc_d = cond_true ? uaddr_in : upc_inc;
                OP_DISPATCH: upc_d = dispatch_addr;
                OP_CALL: begin
                    // Target is taken even when the return address is dropped
                    upc_d = uaddr_in;
                    if (stack_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + PTR_W'(1);
                    end
                end
                OP_RET: begin
                    // Underflow falls back to the fetch routine
                    if (stack_empty) begin
                        upc_d = FETCH_UADDR;
                        unf_d = 1'b1;
                    end else begin
                        upc_d = stack_mem[pop_idx];
                        sp_d  = sp_q - PTR_W'(1);
                    end
                end
                OP_WAIT:     upc_d = ready ? upc_inc : upc_q;
                OP_FETCH:    upc_d = FETCH_UADDR;
                default:     upc_d = upc_inc;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc_q <= FETCH_UADDR;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            upc_q <= upc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; contents are irrelevant after reset
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[push_idx] <= upc_inc;
        end
    end

    assign uaddr     = upc_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
    assign waiting   = (seq_op == OP_WAIT) && !ready;

endmodule

// File: tb/tb_micro_seq.sv
// ---------------------------------------------------------------------------
// tb_micro_seq - directed self-checking bench for micro_seq
//
// Expected uPC values are queued as each microinstruction is driven and
// popped once the clock edge has produced the DUT result.
// ---------------------------------------------------------------------------
module tb_micro_seq;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic [2:0] seq_op;
    logic [2:0] cond_sel;
    logic [7:0] uaddr_in;
    logic [4:0] Opcode;
    logic       ZF;
    logic       CF;
    logic       ready;
    logic [7:0] uaddr;
    logic       waiting;
    logic       stack_ovf;
    logic       stack_unf;

    int n_vec;
    int n_err;
    logic [7:0] exp_q [$];

    micro_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .seq_op    (seq_op),
        .cond_sel  (cond_sel),
        .uaddr_in  (uaddr_in),
        .Opcode    (Opcode),
        .ZF        (ZF),
        .CF        (CF),
        .ready     (ready),
        .uaddr     (uaddr),
        .waiting   (waiting),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one microinstruction: queue its expected uPC, clock it, compare
    task automatic step(input string tag, input logic [2:0] op,
                        input logic [7:0] ain, input logic [7:0] exp);
        logic [7:0] e;
        seq_op   = op;
        uaddr_in = ain;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(tag, {24'h0, uaddr}, {24'h0, e});
    endtask

    // Independent truth table for the branch conditions
    function automatic logic cond_ref(input int cs, input logic z, input logic c);
        logic [7:0] t;
        case (cs)
            0: t = 8'b1010_1010;
            1: t = 8'b0101_0101;
            2: t = 8'b0000_0001;
            3: t = 8'b0000_0011;
            4: t = 8'b0000_1100;
            5: t = 8'b1111_1110;
            6: t = 8'b1111_1111;
            default: t = 8'b0000_0000;
        endcase
        // index = {CF, ZF} mapped onto bit positions 0..3
        return t[{c, z}];
    endfunction

    task automatic do_reset(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        chk({tag, "_uaddr"}, {24'h0, uaddr}, 32'h0);
        chk({tag, "_ovf"}, {31'h0, stack_ovf}, 32'h0);
        chk({tag, "_unf"}, {31'h0, stack_unf}, 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        seq_op   = 3'd0;
        cond_sel = 3'd0;
        uaddr_in = 8'h00;
        Opcode   = 5'd0;
        ZF       = 1'b0;
        CF       = 1'b0;
        ready    = 1'b1;

        // Reset state
        #12;
        chk("rst_uaddr", {24'h0, uaddr}, 32'h0);
        chk("rst_ovf", {31'h0, stack_ovf}, 32'h0);
        chk("rst_unf", {31'h0, stack_unf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Increment and wrap
        step("next1", 3'd0, 8'h00, 8'h01);
        step("next2", 3'd0, 8'h00, 8'h02);
        step("next3", 3'd0, 8'h00, 8'h03);
        step("jump_ff", 3'd1, 8'hFF, 8'hFF);
        step("wrap", 3'd0, 8'h00, 8'h00);
        step("next4", 3'd0, 8'h00, 8'h01);

        // Asynchronous reset mid-sequence, checked before any clock edge
        seq_op = 3'd4;
        uaddr_in = 8'h99;
        do_reset("async_rst");
        step("post_rst", 3'd0, 8'h00, 8'h01);

        // Dispatch and fetch
        Opcode = 5'b01011;
        step("disp_0b", 3'd3, 8'h00, 8'h58);
        Opcode = 5'b10001;
        step("disp_11", 3'd3, 8'h00, 8'h88);
        step("fetch", 3'd7, 8'h00, 8'h00);

        // Conditional branch sweep from 8'h10 to 8'h40
        for (int cs = 0; cs < 8; cs++) begin
            for (int f = 0; f < 4; f++) begin
                step("cj_setup", 3'd1, 8'h10, 8'h10);
                cond_sel = 3'(cs);
                ZF = f[0];
                CF = f[1];
                step($sformatf("cjmp_cs%0d_z%0d_c%0d", cs, f[0], f[1]), 3'd2, 8'h40,
                     cond_ref(cs, f[0], f[1]) ? 8'h40 : 8'h11);
            end
        end
        ZF = 1'b0;
        CF = 1'b0;
        cond_sel = 3'd2;
        step("hi_setup", 3'd1, 8'h10, 8'h10);
        step("hi_z0c0", 3'd2, 8'h40, 8'h40);
        cond_sel = 3'd5;
        CF = 1'b1;
        step("ls_setup", 3'd1, 8'h10, 8'h10);
        step("ls_z0c1", 3'd2, 8'h40, 8'h40);
        CF = 1'b0;

        // Nested call/return
        step("nc_j05", 3'd1, 8'h05, 8'h05);
        step("nc_call20", 3'd4, 8'h20, 8'h20);
        step("nc_next", 3'd0, 8'h00, 8'h21);
        step("nc_call30", 3'd4, 8'h30, 8'h30);
        step("nc_ret22", 3'd5, 8'h00, 8'h22);
        step("nc_ret06", 3'd5, 8'h00, 8'h06);
        chk("nc_ovf", {31'h0, stack_ovf}, 32'h0);
        chk("nc_unf", {31'h0, stack_unf}, 32'h0);

        // Overflow then underflow
        step("ov_j50", 3'd1, 8'h50, 8'h50);
        step("ov_call1", 3'd4, 8'h60, 8'h60);
        step("ov_call2", 3'd4, 8'h70, 8'h70);
        step("ov_call3", 3'd4, 8'h80, 8'h80);
        step("ov_call4", 3'd4, 8'h90, 8'h90);
        chk("ov_flag_pre", {31'h0, stack_ovf}, 32'h0);
        step("ov_call5", 3'd4, 8'hA0, 8'hA0);
        chk("ov_flag", {31'h0, stack_ovf}, 32'h1);
        step("ov_ret1", 3'd5, 8'h00, 8'h81);
        step("ov_ret2", 3'd5, 8'h00, 8'h71);
        step("ov_ret3", 3'd5, 8'h00, 8'h61);
        step("ov_ret4", 3'd5, 8'h00, 8'h51);
        chk("unf_flag_pre", {31'h0, stack_unf}, 32'h0);
        step("un_ret5", 3'd5, 8'h00, 8'h00);
        chk("unf_flag", {31'h0, stack_unf}, 32'h1);
        step("sticky_next", 3'd0, 8'h00, 8'h01);
        chk("sticky_ovf", {31'h0, stack_ovf}, 32'h1);
        chk("sticky_unf", {31'h0, stack_unf}, 32'h1);

        // WAIT holds until ready
        step("w_j12", 3'd1, 8'h12, 8'h12);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seq_op = 3'd6;
            #1;
            chk($sformatf("waiting_%0d", i), {31'h0, waiting}, 32'h1);
            step($sformatf("wait_hold_%0d", i), 3'd6, 8'h00, 8'h12);
        end
        ready = 1'b1;
        #1;
        chk("waiting_rdy", {31'h0, waiting}, 32'h0);
        step("wait_go", 3'd6, 8'h00, 8'h13);

        // Reset clears sticky flags; then stall must block a push
        do_reset("rst2");
        step("st_j13", 3'd1, 8'h13, 8'h13);
        stall = 1'b1;
        step("st_call", 3'd4, 8'h77, 8'h13);
        step("st_next", 3'd0, 8'h00, 8'h13);
        chk("st_ovf", {31'h0, stack_ovf}, 32'h0);
        stall = 1'b0;
        step("st_ret", 3'd5, 8'h00, 8'h00);
        chk("st_unf", {31'h0, stack_unf}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
